// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reverse helper used by the FFT datapath and output reorder.
package fft_pkg;

  localparam int unsigned N      = 256;
  localparam int unsigned LOGN   = 8;
  localparam int unsigned DW     = 16;
  localparam int unsigned BRW    = 16;
  localparam int unsigned BRW_AW = 4;

  // Reverse the low nbits of k; bits above nbits return as zero.
  function automatic logic [BRW-1:0] bit_reverse(input logic [BRW-1:0] k,
                                                 input int unsigned    nbits);
    logic [BRW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BRW); i++) begin
      if (i < int'(nbits)) r[BRW_AW'(i)] = k[BRW_AW'(int'(nbits) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_dpram.sv
// Ping-pong bank storage: simple dual-port RAM, one write port, one registered read port.
module reorder_dpram
  import fft_pkg::*;
#(
  parameter int unsigned AW = LOGN + 1,
  parameter int unsigned W  = 2 * DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_reorder_256.sv
// Bit-reversed to natural-order frame reorder using two ping-pong banks.
// Optional FFT_REORDER_ERR_CNT_EN adds a saturating err_cnt output of discarded frames.
module fft_reorder_256 #(
  parameter int unsigned N  = fft_pkg::N,
  parameter int unsigned DW = fft_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 sop_in,
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  output logic                 valid_out,
  output logic                 sop_out,
  output logic                 eop_out,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im,
  output logic                 frame_err
`ifdef FFT_REORDER_ERR_CNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int unsigned LOG = $clog2(N);
  localparam int unsigned AW  = LOG + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [LOG-1:0] K_LAST = LOG'(N - 1);

  logic [1:0]        state_q, state_d;
  logic [LOG-1:0]    k_q, k_d;
  logic [LOG-1:0]    wr_k;
  logic              wr_en, swap, err_d;
  logic              wbank_q;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic              rd_active_q;
  logic [LOG-1:0]    rd_idx_q;
  logic              s1_valid_q, s1_sop_q, s1_eop_q;
  logic [2*DW-1:0]   rd_data;

  // Write-side next state: DONE is the one-cycle marker after a completed frame and accepts sop like IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wr_en   = 1'b0;
    wr_k    = '0;
    swap    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (valid_in && sop_in) begin
          wr_en   = 1'b1;
          k_d     = LOG'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (valid_in) begin
          wr_en = 1'b1;
          if (sop_in) begin
            err_d = 1'b1;
            k_d   = LOG'(1);
          end else begin
            wr_k = k_q;
            if (k_q == K_LAST) begin
              swap    = 1'b1;
              k_d     = '0;
              state_d = DONE;
            end else begin
              k_d = k_q + LOG'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      wbank_q   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wbank_q   <= wbank_q ^ swap;
      frame_err <= err_d;
    end
  end

  assign wr_addr = {wbank_q, LOG'(fft_pkg::bit_reverse(fft_pkg::BRW'(wr_k), LOG))};
  assign rd_addr = {~wbank_q, rd_idx_q};

  reorder_dpram #(
    .AW (AW),
    .W  (2 * DW)
  ) u_dpram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata ({x_re, x_im}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Read sweep over the just-filled bank; a swap always lands after the previous sweep ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_active_q <= 1'b0;
      rd_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_sop_q    <= 1'b0;
      s1_eop_q    <= 1'b0;
    end else begin
      if (swap) begin
        rd_active_q <= 1'b1;
        rd_idx_q    <= '0;
      end else if (rd_active_q) begin
        rd_idx_q <= rd_idx_q + LOG'(1);
        if (rd_idx_q == K_LAST) rd_active_q <= 1'b0;
      end
      s1_valid_q <= rd_active_q;
      s1_sop_q   <= rd_active_q && (rd_idx_q == '0);
      s1_eop_q   <= rd_active_q && (rd_idx_q == K_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
    end else begin
      valid_out <= s1_valid_q;
      sop_out   <= s1_sop_q;
      eop_out   <= s1_eop_q;
      y_re      <= s1_valid_q ? rd_data[2*DW-1:DW] : '0;
      y_im      <= s1_valid_q ? rd_data[DW-1:0]    : '0;
    end
  end

`ifdef FFT_REORDER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err_cnt <= 8'd0;
    else if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fft_reorder_256.sv
// Randomized self-checking bench for fft_reorder_256 against a frame-level reorder model.
module tb_fft_reorder_256;

  localparam int N = 256;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic               sop_in = 1'b0;
  logic signed [15:0] x_re = '0;
  logic signed [15:0] x_im = '0;
  logic               valid_out, sop_out, eop_out, frame_err;
  logic signed [15:0] y_re, y_im;
`ifdef FFT_REORDER_ERR_CNT_EN
  logic [7:0]         err_cnt;
`endif

  fft_reorder_256 #(.N(256), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .x_re      (x_re),
    .x_im      (x_im),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .y_re      (y_re),
    .y_im      (y_im),
    .frame_err (frame_err)
`ifdef FFT_REORDER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] got_re[$], got_im[$], exp_re[$], exp_im[$];
  bit                 got_sop[$], got_eop[$];
  int                 got_cyc[$];
  int                 err_pulses = 0;
  int                 idle_bad = 0;
  int                 last_wr_cyc = 0;

  // Output recorder
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      got_re.push_back(y_re);
      got_im.push_back(y_im);
      got_sop.push_back(sop_out);
      got_eop.push_back(eop_out);
      got_cyc.push_back(cyc);
    end else if (y_re !== 16'sd0 || y_im !== 16'sd0 || sop_out !== 1'b0 || eop_out !== 1'b0) begin
      idle_bad++;
    end
    if (frame_err === 1'b1) err_pulses++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic drive(input bit v, input bit s, input int re, input int im);
    @(posedge clk);
    #1;
    valid_in = v;
    sop_in   = s;
    x_re     = 16'(re);
    x_im     = 16'(im);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic clear_mon();
    got_re.delete(); got_im.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    exp_re.delete(); exp_im.delete();
    err_pulses = 0;
    idle_bad   = 0;
  endtask

  // Sends one frame in bit-reversed order; model: sample k lands at address brev(k), read out 0..N-1.
  task automatic send_frame(input int off, input bit ramp, input int gap_pct);
    logic signed [15:0] mre[N];
    logic signed [15:0] mim[N];
    logic signed [15:0] sre, sim;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        for (int g = 0; g < 16 && int'($urandom_range(0, 99)) < gap_pct; g++)
          drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      if (ramp) begin
        sre = 16'(off + brev(k));
        sim = 16'(-(off + brev(k)));
      end else begin
        sre = 16'($urandom);
        sim = 16'($urandom);
      end
      drive(1'b1, k == 0, int'(sre), int'(sim));
      mre[brev(k)] = sre;
      mim[brev(k)] = sim;
    end
    last_wr_cyc = cyc + 1;
    for (int j = 0; j < N; j++) begin
      exp_re.push_back(mre[j]);
      exp_im.push_back(mim[j]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_out, sop_out, eop_out, frame_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {valid_out, sop_out, eop_out, frame_err});
    end
    checks++;
    if (y_re !== 16'sd0 || y_im !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data: got %0d/%0d required 0/0", y_re, y_im);
    end
`ifdef FFT_REORDER_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, $urandom, $urandom);
    drive_idle(5);
    checks++;
    if (got_re.size() != 0 || err_pulses != 0 || idle_bad != 0) begin
      errors++;
      $display("FAIL idle_no_sop: got %0d outputs %0d errs %0d idle_bad, required 0/0/0",
               got_re.size(), err_pulses, idle_bad);
    end
  endtask

  task automatic test_ramp();
    clear_mon();
    send_frame(0, 1'b1, 0);
    drive_idle(270);
    checks++;
    if (got_re.size() != N) begin
      errors++;
      $display("FAIL ramp_count: got %0d required %0d", got_re.size(), N);
    end
    for (int j = 0; j < N && j < got_re.size(); j++) begin
      checks++;
      if (got_re[j] !== 16'(j) || got_im[j] !== 16'(-j)) begin
        errors++;
        $display("FAIL ramp_data[%0d]: got %0d/%0d required %0d/%0d", j, got_re[j], got_im[j], j, -j);
      end
      checks++;
      if (got_sop[j] !== (j == 0) || got_eop[j] !== (j == N - 1) || got_cyc[j] != last_wr_cyc + 2 + j) begin
        errors++;
        $display("FAIL ramp_timing[%0d]: got sop=%0d eop=%0d cyc=%0d required sop=%0d eop=%0d cyc=%0d",
                 j, got_sop[j], got_eop[j], got_cyc[j], j == 0, j == N - 1, last_wr_cyc + 2 + j);
      end
    end
    checks++;
    if (err_pulses != 0 || idle_bad != 0) begin
      errors++;
      $display("FAIL ramp_clean: got %0d errs %0d idle_bad required 0/0", err_pulses, idle_bad);
    end
  endtask

  task automatic test_back_to_back();
    int wr1, e;
    clear_mon();
    send_frame(0, 1'b1, 0);
    wr1 = last_wr_cyc;
    send_frame(1000, 1'b1, 0);
    drive_idle(270);
    checks++;
    if (got_re.size() != 2 * N || err_pulses != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d samples %0d errs required %0d/0", got_re.size(), err_pulses, 2 * N);
    end
    for (int j = 0; j < 2 * N && j < got_re.size(); j++) begin
      e = (j < N) ? j : 1000 + j - N;
      checks++;
      if (got_re[j] !== 16'(e) || got_im[j] !== 16'(-e) || got_cyc[j] != wr1 + 2 + j ||
          got_sop[j] !== (j % N == 0) || got_eop[j] !== (j % N == N - 1)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %0d/%0d cyc=%0d sop=%0d eop=%0d required %0d/%0d cyc=%0d sop=%0d eop=%0d",
                 j, got_re[j], got_im[j], got_cyc[j], got_sop[j], got_eop[j],
                 e, -e, wr1 + 2 + j, j % N == 0, j % N == N - 1);
      end
    end
  endtask

  task automatic test_abort();
    clear_mon();
    for (int k = 0; k <= 100; k++) drive(1'b1, k == 0, $urandom, $urandom);
    send_frame(0, 1'b0, 0);
    drive_idle(270);
    checks++;
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL abort_err_pulse: got %0d cycles required 1", err_pulses);
    end
    checks++;
    if (got_re.size() != N) begin
      errors++;
      $display("FAIL abort_count: got %0d required %0d", got_re.size(), N);
    end
    for (int j = 0; j < N && j < got_re.size(); j++) begin
      checks++;
      if (got_re[j] !== exp_re[j] || got_im[j] !== exp_im[j] ||
          got_sop[j] !== (j == 0) || got_eop[j] !== (j == N - 1)) begin
        errors++;
        $display("FAIL abort_data[%0d]: got %0d/%0d sop=%0d eop=%0d required %0d/%0d",
                 j, got_re[j], got_im[j], got_sop[j], got_eop[j], exp_re[j], exp_im[j]);
      end
    end
  endtask

  task automatic test_gaps();
    clear_mon();
    send_frame(0, 1'b0, 50);
    drive_idle(270);
    checks++;
    if (got_re.size() != N || err_pulses != 0 || idle_bad != 0) begin
      errors++;
      $display("FAIL gaps_count: got %0d samples %0d errs %0d idle_bad required %0d/0/0",
               got_re.size(), err_pulses, idle_bad, N);
    end
    for (int j = 0; j < N && j < got_re.size(); j++) begin
      checks++;
      if (got_re[j] !== exp_re[j] || got_im[j] !== exp_im[j] || got_cyc[j] != last_wr_cyc + 2 + j ||
          got_sop[j] !== (j == 0) || got_eop[j] !== (j == N - 1)) begin
        errors++;
        $display("FAIL gaps_data[%0d]: got %0d/%0d cyc=%0d required %0d/%0d cyc=%0d",
                 j, got_re[j], got_im[j], got_cyc[j], exp_re[j], exp_im[j], last_wr_cyc + 2 + j);
      end
    end
  endtask

`ifdef FFT_REORDER_ERR_CNT_EN
  task automatic test_err_cnt();
    clear_mon();
    for (int i = 0; i < 301; i++) begin
      drive(1'b1, 1'b1, $urandom, $urandom);
      drive(1'b1, 1'b0, $urandom, $urandom);
    end
    drive_idle(3);
    checks++;
    if (err_cnt !== 8'd255 || err_pulses != 300) begin
      errors++;
      $display("FAIL err_cnt_sat: got cnt=%0d pulses=%0d required 255/300", err_cnt, err_pulses);
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    int t;
    clear_mon();
    send_frame(0, 1'b0, 0);
    drive_idle(1);
    t = 0;
    while (got_re.size() < 40 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (got_re.size() != 40) begin
      errors++;
      $display("FAIL rst_mid_reach: got %0d samples required 40", got_re.size());
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({valid_out, sop_out, eop_out, frame_err} !== 4'b0 || y_re !== 16'sd0 || y_im !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got flags=%b data=%0d/%0d required 0000 0/0",
               {valid_out, sop_out, eop_out, frame_err}, y_re, y_im);
    end
`ifdef FFT_REORDER_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_err_cnt: got %0d required 0", err_cnt);
    end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_idle(300);
    checks++;
    if (got_re.size() != 40 || idle_bad != 0) begin
      errors++;
      $display("FAIL rst_mid_silence: got %0d samples %0d idle_bad required 40/0", got_re.size(), idle_bad);
    end
    clear_mon();
    send_frame(0, 1'b0, 0);
    drive_idle(270);
    checks++;
    if (got_re.size() != N) begin
      errors++;
      $display("FAIL rst_mid_next_count: got %0d required %0d", got_re.size(), N);
    end
    for (int j = 0; j < N && j < got_re.size(); j++) begin
      checks++;
      if (got_re[j] !== exp_re[j] || got_im[j] !== exp_im[j] || got_cyc[j] != last_wr_cyc + 2 + j) begin
        errors++;
        $display("FAIL rst_mid_next[%0d]: got %0d/%0d cyc=%0d required %0d/%0d cyc=%0d",
                 j, got_re[j], got_im[j], got_cyc[j], exp_re[j], exp_im[j], last_wr_cyc + 2 + j);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_abort();
    test_gaps();
`ifdef FFT_REORDER_ERR_CNT_EN
    test_err_cnt();
`endif
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
